qif_run_ctrl: RTL and testbench
===============================

Name: qif_run_ctrl

Overview:
- Sequencer and configuration controller for the 8-bit QIF neuron datapath.
- Loads neuron parameters over a byte-wide checksummed config stream, then paces the neuron integration step via a programmable divider.
- Enforces a refractory window after each spike and counts spikes.
- Sits between the top-level pin interface and the QIF update core.

Parameters:
- HDR, 8'hA5, config frame header byte
- REFRACT_CYC, 4, cycles step_en is suppressed after a spike (>=1)
- V_TH_RST, 8'd200, reset value of v_th
- V_RESET_RST, 8'd0, reset value of v_reset
- LEAK_RST, 3'd2, reset value of leak_shift
- DIV_RST, 8'd0, reset value of step_div

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes all state
- cfg_valid  in  1  cfg_byte valid
- cfg_byte  in  8  config stream byte
- cfg_ready  out  1  controller can accept a config byte
- start  in  1  begin stepping (level sampled)
- stop  in  1  halt stepping / abort load
- spike_in  in  1  spike flag from QIF core
- v_th  out  8  active threshold
- v_reset  out  8  active post-spike membrane value
- leak_shift  out  3  active leak shift amount
- step_div  out  8  active step divider
- step_en  out  1  one-cycle integrate-step strobe to core
- load_vreset  out  1  one-cycle strobe: core loads v_reset into membrane
- running  out  1  high in RUN or REFRACT
- cfg_done  out  1  one-cycle pulse after successful commit
- cfg_err  out  1  sticky checksum-error flag
- spike_count  out  8  saturating spike counter

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - Active registers take the *_RST values.
  - step_en, load_vreset, cfg_done, cfg_err, running = 0.
  - spike_count = 0; divider and refractory counters = 0.
- ena=0:
  - No state, counter or register changes.
  - step_en, load_vreset, cfg_done forced 0.
  - cfg_ready = 0.
- Byte transfer: a byte is accepted on a rising edge with cfg_valid & cfg_ready. cfg_ready = ena & (state is IDLE or LOAD).
- FSM states: IDLE, LOAD, RUN, REFRACT.
- IDLE:
  - Accepted byte == HDR: go to LOAD, idx=0, shadow XOR=0, clear cfg_err.
  - Any other accepted byte is discarded.
  - start=1 & stop=0 (and no accepted HDR in the same cycle): go to RUN, divider=0.
  - If an accepted HDR and start coincide, HDR wins.
- LOAD:
  - Accepted bytes idx 0..3 go to shadow v_th, v_reset, leak_shift (bits [2:0]; bits [7:3] included in XOR), step_div. Running XOR is updated per byte.
  - Byte idx 4 is the checksum:
    - If it equals the XOR, shadow is copied to active registers on that edge, and cfg_done pulses the next cycle.
    - Otherwise cfg_err=1 and active registers are unchanged.
    - Either way, return to IDLE.
  - stop=1 aborts the load: go to IDLE, shadow discarded, no error, and a byte accepted that cycle is discarded.
  - start is ignored.
- RUN:
  - Divider counts 0..step_div.
  - When the count equals step_div and spike_in=0, step_en=1 for that cycle and the divider wraps to 0.
  - step_div=0 gives step_en every cycle.
  - spike_in=1:
    - spike_count += 1, saturating at 255.
    - load_vreset pulses the next cycle.
    - step_en is 0 that cycle; go to REFRACT with refractory counter = REFRACT_CYC-1.
  - stop=1 has priority over spike: go to IDLE, step_en=0, spike not counted.
- REFRACT:
  - step_en=0; spike_in ignored.
  - Counter decrements; at 0 return to RUN with divider=0.
  - stop=1 goes to IDLE.
- Active parameter registers change only via commit. No config is possible while running.
- spike_count clears only on reset or on a successful commit.
- All outputs are registered except cfg_ready and running (decoded from state).

Test Plan:
- Reset defaults: release rst_n with ena=1 -> v_th=200, v_reset=0, leak_shift=2, step_div=0, spike_count=0, cfg_ready=1.
- Good frame: send A5,C8,10,03,04,DF (XOR of C8,10,03,04 = DF) -> v_th=C8, v_reset=10, leak_shift=3, step_div=4; cfg_done one pulse; cfg_err=0.
- Bad frame: A5,C8,10,03,04,00 -> cfg_err=1, registers keep previous values. A subsequent A5 clears cfg_err.
- Pacing: step_div=4, start one cycle -> step_en every 5th cycle (first pulse 5 cycles after RUN entry). Apply stop -> step_en stays 0, running=0.
- Spike/refractory: in RUN with step_div=0, pulse spike_in -> spike_count=1, load_vreset 1 cycle later, step_en=0 for 4 cycles, then resumes every cycle. A spike during REFRACT is not counted.
- Corners: 256 spikes -> spike_count saturates at 255. stop mid-LOAD after 2 bytes -> IDLE, registers unchanged. ena=0 mid-RUN freezes the divider, then resumes the count. rst_n asserted mid-LOAD -> all defaults.

Source files
------------

// File: rtl/qif_run_ctrl.sv
// Run/config controller for the QIF neuron: checksummed parameter load,
// divider-paced integrate steps, refractory window and spike counting.
//
// state   | meaning
// IDLE    | waiting for a frame header or start
// LOAD    | collecting 4 parameter bytes plus checksum
// RUN     | pacing step_en through the divider
// REFRACT | post-spike hold-off, step_en suppressed
module qif_run_ctrl #(
    parameter logic [7:0] HDR         = 8'hA5,
    parameter int         REFRACT_CYC = 4,
    parameter logic [7:0] V_TH_RST    = 8'd200,
    parameter logic [7:0] V_RESET_RST = 8'd0,
    parameter logic [2:0] LEAK_RST    = 3'd2,
    parameter logic [7:0] DIV_RST     = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cfg_valid,
    input  logic [7:0] cfg_byte,
    output logic       cfg_ready,
    input  logic       start,
    input  logic       stop,
    input  logic       spike_in,
    output logic [7:0] v_th,
    output logic [7:0] v_reset,
    output logic [2:0] leak_shift,
    output logic [7:0] step_div,
    output logic       step_en,
    output logic       load_vreset,
    output logic       running,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [7:0] spike_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, REFRACT} state_t;

    localparam logic [7:0] REF_INIT = 8'(REFRACT_CYC - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] xor_q, xor_d;
    logic [7:0] sh_vth_q, sh_vth_d;
    logic [7:0] sh_vrst_q, sh_vrst_d;
    logic [2:0] sh_leak_q, sh_leak_d;
    logic [7:0] sh_div_q, sh_div_d;
    logic [7:0] vth_q, vth_d;
    logic [7:0] vrst_q, vrst_d;
    logic [2:0] leak_q, leak_d;
    logic [7:0] div_cfg_q, div_cfg_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [7:0] ref_cnt_q, ref_cnt_d;
    logic [7:0] spk_q, spk_d;
    logic       step_q, step_d;
    logic       lvr_q, lvr_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       byte_acc;

    assign cfg_ready = ena & ((state_q == IDLE) | (state_q == LOAD));
    assign running   = (state_q == RUN) | (state_q == REFRACT);
    assign byte_acc  = cfg_valid & cfg_ready;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        xor_d     = xor_q;
        sh_vth_d  = sh_vth_q;
        sh_vrst_d = sh_vrst_q;
        sh_leak_d = sh_leak_q;
        sh_div_d  = sh_div_q;
        vth_d     = vth_q;
        vrst_d    = vrst_q;
        leak_d    = leak_q;
        div_cfg_d = div_cfg_q;
        div_cnt_d = div_cnt_q;
        ref_cnt_d = ref_cnt_q;
        spk_d     = spk_q;
        err_d     = err_q;
        step_d    = 1'b0;
        lvr_d     = 1'b0;
        done_d    = 1'b0;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    // A header outranks a coincident start
                    if (byte_acc && (cfg_byte == HDR)) begin
                        state_d = LOAD;
                        idx_d   = 3'd0;
                        xor_d   = 8'd0;
                        err_d   = 1'b0;
                    end else if (start && !stop) begin
                        state_d   = RUN;
                        div_cnt_d = 8'd0;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (byte_acc) begin
                        if (idx_q == 3'd4) begin
                            if (cfg_byte == xor_q) begin
                                vth_d     = sh_vth_q;
                                vrst_d    = sh_vrst_q;
                                leak_d    = sh_leak_q;
                                div_cfg_d = sh_div_q;
                                spk_d     = 8'd0;
                                done_d    = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                            state_d = IDLE;
                        end else begin
                            case (idx_q[1:0])
                                2'd0:    sh_vth_d  = cfg_byte;
                                2'd1:    sh_vrst_d = cfg_byte;
                                2'd2:    sh_leak_d = cfg_byte[2:0];
                                default: sh_div_d  = cfg_byte;
                            endcase
                            xor_d = xor_q ^ cfg_byte;
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (spike_in) begin
                        if (spk_q != 8'hFF) spk_d = spk_q + 8'd1;
                        lvr_d     = 1'b1;
                        ref_cnt_d = REF_INIT;
                        state_d   = REFRACT;
                    end else if (div_cnt_q == div_cfg_q) begin
                        step_d    = 1'b1;
                        div_cnt_d = 8'd0;
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
                REFRACT: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (ref_cnt_q == 8'd0) begin
                        state_d   = RUN;
                        div_cnt_d = 8'd0;
                    end else begin
                        ref_cnt_d = ref_cnt_q - 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            xor_q     <= 8'd0;
            sh_vth_q  <= 8'd0;
            sh_vrst_q <= 8'd0;
            sh_leak_q <= 3'd0;
            sh_div_q  <= 8'd0;
            vth_q     <= V_TH_RST;
            vrst_q    <= V_RESET_RST;
            leak_q    <= LEAK_RST;
            div_cfg_q <= DIV_RST;
            div_cnt_q <= 8'd0;
            ref_cnt_q <= 8'd0;
            spk_q     <= 8'd0;
            step_q    <= 1'b0;
            lvr_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            xor_q     <= xor_d;
            sh_vth_q  <= sh_vth_d;
            sh_vrst_q <= sh_vrst_d;
            sh_leak_q <= sh_leak_d;
            sh_div_q  <= sh_div_d;
            vth_q     <= vth_d;
            vrst_q    <= vrst_d;
            leak_q    <= leak_d;
            div_cfg_q <= div_cfg_d;
            div_cnt_q <= div_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            spk_q     <= spk_d;
            step_q    <= step_d;
            lvr_q     <= lvr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Strobes are masked by ena so a pulse never leaks out while frozen
    assign step_en     = step_q & ena;
    assign load_vreset = lvr_q & ena;
    assign cfg_done    = done_q & ena;
    assign cfg_err     = err_q;
    assign v_th        = vth_q;
    assign v_reset     = vrst_q;
    assign leak_shift  = leak_q;
    assign step_div    = div_cfg_q;
    assign spike_count = spk_q;

endmodule

// File: tb/tb_qif_run_ctrl.sv
// Randomized scoreboard bench for qif_run_ctrl: a frame/phase-level reference
// model predicts every cycle's outputs; a separate monitor compares them.
module tb_qif_run_ctrl;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int REFRACT_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_byte = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       spike_in = 1'b0;
    logic       cfg_ready, step_en, load_vreset, running, cfg_done, cfg_err;
    logic [7:0] v_th, v_reset, step_div, spike_count;
    logic [2:0] leak_shift;

    qif_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_valid(cfg_valid),
        .cfg_byte(cfg_byte), .cfg_ready(cfg_ready), .start(start), .stop(stop),
        .spike_in(spike_in), .v_th(v_th), .v_reset(v_reset),
        .leak_shift(leak_shift), .step_div(step_div), .step_en(step_en),
        .load_vreset(load_vreset), .running(running), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vth, vrst, div, cnt;
        logic [2:0] leak;
        logic step, lvr, done, err, run, rdy;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Reference model: frame-level load, phase-count pacing, hold-off countdown
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_REFR} mode_t;
    mode_t      m_mode;
    logic [7:0] frame[$];
    logic [7:0] a_vth, a_vrst, a_div;
    logic [2:0] a_leak;
    int         phase, refr_left, spikes;
    bit         m_err, e_step, e_lvr, e_done;

    task automatic model_reset();
        m_mode = M_IDLE;
        frame.delete();
        a_vth = 8'd200; a_vrst = 8'd0; a_leak = 3'd2; a_div = 8'd0;
        phase = 0; refr_left = 0; spikes = 0;
        m_err = 0; e_step = 0; e_lvr = 0; e_done = 0;
    endtask

    task automatic model_step();
        bit acc;
        logic [7:0] x;
        e_step = 0; e_lvr = 0; e_done = 0;
        if (!rst_n || !ena) return;
        acc = cfg_valid && (m_mode == M_IDLE || m_mode == M_LOAD);
        case (m_mode)
            M_IDLE: begin
                if (acc && cfg_byte == HDR) begin
                    m_mode = M_LOAD; frame.delete(); m_err = 0;
                end else if (start && !stop) begin
                    m_mode = M_RUN; phase = 0;
                end
            end
            M_LOAD: begin
                if (stop) begin
                    m_mode = M_IDLE; frame.delete();
                end else if (acc) begin
                    if (frame.size() < 4) frame.push_back(cfg_byte);
                    else begin
                        x = 8'd0;
                        foreach (frame[i]) x ^= frame[i];
                        if (x == cfg_byte) begin
                            a_vth = frame[0]; a_vrst = frame[1];
                            a_leak = frame[2][2:0]; a_div = frame[3];
                            spikes = 0; e_done = 1;
                        end else m_err = 1;
                        m_mode = M_IDLE;
                    end
                end
            end
            M_RUN: begin
                if (stop) m_mode = M_IDLE;
                else if (spike_in) begin
                    spikes = (spikes >= 255) ? 255 : spikes + 1;
                    e_lvr = 1; m_mode = M_REFR; refr_left = REFRACT_CYC;
                end else begin
                    if ((phase + 1) % (int'(a_div) + 1) == 0) e_step = 1;
                    phase++;
                end
            end
            default: begin
                if (stop) m_mode = M_IDLE;
                else begin
                    refr_left--;
                    if (refr_left == 0) begin m_mode = M_RUN; phase = 0; end
                end
            end
        endcase
    endtask

    task automatic push_expect();
        exp_t x;
        x.vth = a_vth; x.vrst = a_vrst; x.leak = a_leak; x.div = a_div;
        x.cnt = 8'(spikes);
        x.step = e_step & ena; x.lvr = e_lvr & ena; x.done = e_done & ena;
        x.err = m_err;
        x.run = (m_mode == M_RUN || m_mode == M_REFR);
        x.rdy = ena && (m_mode == M_IDLE || m_mode == M_LOAD);
        exp_q.push_back(x);
    endtask

    // One clock: model consumes the inputs the DUT samples, then new inputs apply
    task automatic drive(input bit r, input bit e, input bit v, input logic [7:0] b,
                         input bit st, input bit sp, input bit sk);
        @(posedge clk);
        model_step();
        #1;
        rst_n = r; ena = e; cfg_valid = v; cfg_byte = b;
        start = st; stop = sp; spike_in = sk;
        if (!rst_n) model_reset();
        push_expect();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 1, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3,
                              input logic [7:0] ck);
        drive(1, 1, 1, HDR, 0, 0, 0);
        drive(1, 1, 1, p0, 0, 0, 0);
        drive(1, 1, 1, p1, 0, 0, 0);
        drive(1, 1, 1, p2, 0, 0, 0);
        drive(1, 1, 1, p3, 0, 0, 0);
        drive(1, 1, 1, ck, 0, 0, 0);
        idle(2);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("params", {v_th, v_reset, 5'd0, leak_shift, step_div},
                    {x.vth, x.vrst, 5'd0, x.leak, x.div});
                chk("step_en", 32'(step_en), 32'(x.step));
                chk("load_vreset", 32'(load_vreset), 32'(x.lvr));
                chk("cfg_done", 32'(cfg_done), 32'(x.done));
                chk("cfg_err", 32'(cfg_err), 32'(x.err));
                chk("running", 32'(running), 32'(x.run));
                chk("cfg_ready", 32'(cfg_ready), 32'(x.rdy));
                chk("spike_count", 32'(spike_count), 32'(x.cnt));
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [7:0] p0, p1, p2, p3;
        model_reset();
        drive(0, 1, 0, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 8'h00, 0, 0, 0);
        drive(1, 1, 0, 8'h00, 0, 0, 0);
        idle(3);

        // good frame, bad frame, header clears the error via abort
        send_frame(8'hC8, 8'h10, 8'h03, 8'h04, 8'hDF);
        send_frame(8'hC8, 8'h10, 8'h03, 8'h04, 8'h00);
        drive(1, 1, 1, HDR, 0, 0, 0);
        drive(1, 1, 0, 8'h00, 0, 1, 0);
        idle(2);

        // abort after two bytes, byte offered alongside stop is dropped
        drive(1, 1, 1, HDR, 0, 0, 0);
        drive(1, 1, 1, 8'h11, 0, 0, 0);
        drive(1, 1, 1, 8'h22, 0, 0, 0);
        drive(1, 1, 1, 8'h33, 0, 1, 0);
        idle(3);

        // pacing at step_div=4, then stop
        drive(1, 1, 0, 8'h00, 1, 0, 0);
        idle(22);
        drive(1, 1, 0, 8'h00, 0, 1, 0);
        idle(4);

        // ena freeze mid-run
        drive(1, 1, 0, 8'h00, 1, 0, 0);
        idle(7);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'h00, 0, 0, 0);
        idle(12);
        drive(1, 1, 0, 8'h00, 0, 1, 0);

        // step_div=0, single spike, spike during hold-off, then saturation
        send_frame(8'hC8, 8'h10, 8'h03, 8'h00, 8'hDB);
        drive(1, 1, 0, 8'h00, 1, 0, 0);
        idle(3);
        drive(1, 1, 0, 8'h00, 0, 0, 1);
        drive(1, 1, 0, 8'h00, 0, 0, 0);
        drive(1, 1, 0, 8'h00, 0, 0, 1);
        idle(8);
        for (int i = 0; i < 1300; i++) drive(1, 1, 0, 8'h00, 0, 0, 1);
        drive(1, 1, 0, 8'h00, 0, 1, 0);
        idle(2);

        // reset in the middle of a load
        drive(1, 1, 1, HDR, 0, 0, 0);
        drive(1, 1, 1, 8'h01, 0, 0, 0);
        drive(1, 1, 1, 8'h02, 0, 0, 0);
        drive(0, 1, 0, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 8'h00, 0, 0, 0);
        drive(1, 1, 0, 8'h00, 0, 0, 0);
        idle(2);

        // randomized traffic with periodic valid frames
        for (int blk = 0; blk < 40; blk++) begin
            drive(1, 1, 0, 8'h00, 0, 1, 0);
            p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
            p3 = 8'($urandom_range(0, 6));
            send_frame(p0, p1, p2, p3, p0 ^ p1 ^ p2 ^ p3);
            for (int i = 0; i < 70; i++) begin
                drive(1, ($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                      ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                      ($urandom_range(0, 5) == 0));
            end
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
